// File: rtl/mic_pkg.sv
// rtl/mic_pkg.sv - shared types, constants and helpers for the mic ADC capture front end
package mic_pkg;

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, DONE, GAP} mic_state_t;

  // Smallest tick period minus 1 that still leaves room for the MISO synchroniser.
  localparam int MIN_DIV = 2;

  function automatic int sat_u(input int v, input int max_v);
    if (v < 0) return 0;
    if (v > max_v) return max_v;
    return v;
  endfunction

endpackage

// File: rtl/mic_capture_sclk_tick_gen.sv
// rtl/mic_capture_sclk_tick_gen.sv - SCLK tick divider with clamped divider latch
// Counter runs 0..div_q; the divider is latched only on a load tick.
module sclk_tick_gen
  import mic_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 hold,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] MIN_DIV_W = DIV_WIDTH'(MIN_DIV);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;

  always_comb begin
    tick  = !hold && (cnt_q == div_q);
    cnt_d = cnt_q;
    div_d = div_q;
    if (!hold) cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (load && tick) div_d = (div < MIN_DIV_W) ? MIN_DIV_W : div;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= MIN_DIV_W;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/mic_capture.sv
// rtl/mic_capture.sv - SPI-style mic ADC frame sequencer and MSB-first deserialiser
// Optional DC-removal output stage selected by MIC_DC_BLOCK_EN.
module mic_capture
  import mic_pkg::*;
#(
  parameter int ADC_BITS  = 12,
  parameter int S_WIDTH   = 8,
  parameter int DIV_WIDTH = 8,
  parameter int GAP_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 adc_miso,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic [S_WIDTH-1:0]   sample,
  output logic                 sample_valid,
  output logic                 busy
);

  localparam int CNT_W = $clog2(ADC_BITS + 1);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  mic_state_t           state_q, state_d;
  logic                 sclk_q, sclk_d;
  logic [ADC_BITS-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [S_WIDTH-1:0]   sample_q, sample_d;
  logic                 miso_meta_q, miso_meta_d;
  logic                 miso_sync_q, miso_sync_d;
  logic [S_WIDTH-1:0]   raw;
  logic                 tick;

`ifdef MIC_DC_BLOCK_EN
  localparam int ACC_W = S_WIDTH + 4;
  localparam logic [ACC_W-1:0] ACC_RST = ACC_W'((2 ** (S_WIDTH - 1)) * 16);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             valid_q, valid_d;
  int               x_i, acc_i, y_i;
`endif

  sclk_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .load (state_q == IDLE && en),
    .hold (state_q == DONE),
    .div  (div),
    .tick (tick)
  );

  assign raw = shreg_q[ADC_BITS-1 -: S_WIDTH];

  always_comb begin
    state_d     = state_q;
    sclk_d      = sclk_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    sample_d    = sample_q;
    miso_meta_d = adc_miso;
    miso_sync_d = miso_meta_q;
    case (state_q)
      IDLE: if (tick && en) state_d = CS_SETUP;
      CS_SETUP: if (tick) begin
        state_d   = SHIFT;
        sclk_d    = 1'b0;
        bit_cnt_d = '0;
      end
      SHIFT: if (tick) begin
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          shreg_d   = {shreg_q[ADC_BITS-2:0], miso_sync_q};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (bit_cnt_q == CNT_W'(ADC_BITS)) begin
          state_d = DONE;
`ifndef MIC_DC_BLOCK_EN
          sample_d = raw;
`endif
        end
      end
      DONE: begin
        state_d   = GAP;
        gap_cnt_d = '0;
      end
      GAP: if (tick) begin
        if (gap_cnt_q == GAP_W'(GAP_TICKS - 1)) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
`ifdef MIC_DC_BLOCK_EN
    // EMA tracks the DC level; the output uses the estimate from before this sample.
    acc_d   = acc_q;
    valid_d = 1'b0;
    x_i     = int'(raw);
    acc_i   = int'(acc_q);
    y_i     = x_i - (acc_i >>> 4) + 2 ** (S_WIDTH - 1);
    if (state_q == DONE) begin
      acc_d    = ACC_W'(acc_i + x_i - (acc_i >>> 4));
      sample_d = S_WIDTH'(sat_u(y_i, 2 ** S_WIDTH - 1));
      valid_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_q      <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      sample_q    <= '0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
`ifdef MIC_DC_BLOCK_EN
      acc_q       <= ACC_RST;
      valid_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sclk_q      <= sclk_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sample_q    <= sample_d;
      miso_meta_q <= miso_meta_d;
      miso_sync_q <= miso_sync_d;
`ifdef MIC_DC_BLOCK_EN
      acc_q       <= acc_d;
      valid_q     <= valid_d;
`endif
    end
  end

  assign adc_cs_n = !(state_q == CS_SETUP || state_q == SHIFT);
  assign adc_sclk = sclk_q;
  assign busy     = (state_q != IDLE);
  assign sample   = sample_q;
`ifdef MIC_DC_BLOCK_EN
  assign sample_valid = valid_q;
`else
  assign sample_valid = (state_q == DONE);
`endif

endmodule

// File: tb/tb_mic_capture.sv
// tb/tb_mic_capture.sv - directed and randomised bench for mic_capture with an ADC model
module tb_mic_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] div = 8'd3;
  logic       adc_miso = 1'b0;
  logic       adc_cs_n, adc_sclk, sample_valid, busy;
  logic [7:0] sample;

  always #5 clk = ~clk;

  mic_capture dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .div          (div),
    .adc_miso     (adc_miso),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;

  // ADC model and observation log, all updated away from the active edge.
  logic        fixed_mode = 1'b1;
  logic [11:0] fixed_word = 12'hA5C;
  logic [11:0] adc_word = 12'h000;
  int          adc_bit = 0;
  logic        cs_prev = 1'b1;
  logic        sclk_prev = 1'b0;
  int          cyc = 0;
  int          frame_rises = 0;
  int          cs_run = 0;
  logic [11:0] sent_q[$];
  int          val_t[$];
  logic [7:0]  val_s[$];
  logic [11:0] val_w[$];
  int          rise_t[$];
  int          cs_len[$];

  always @(negedge clk) begin
    cyc++;
    if (!adc_cs_n && cs_prev) begin
      adc_word = fixed_mode ? fixed_word : 12'($urandom);
      sent_q.push_back(adc_word);
      adc_bit = 11;
      adc_miso = adc_word[11];
      frame_rises = 0;
      cs_run = 0;
    end else if (!adc_cs_n && !adc_sclk && sclk_prev) begin
      adc_bit--;
      adc_miso = (adc_bit >= 0) ? adc_word[adc_bit] : 1'($urandom);
    end
    if (adc_sclk && !sclk_prev) begin
      rise_t.push_back(cyc);
      frame_rises++;
    end
    if (!adc_cs_n) cs_run++;
    else if (!cs_prev) cs_len.push_back(cs_run);
    if (sample_valid) begin
      val_t.push_back(cyc);
      val_s.push_back(sample);
      val_w.push_back(sent_q.size() > 0 ? sent_q[sent_q.size()-1] : 12'h000);
    end
    cs_prev = adc_cs_n;
    sclk_prev = adc_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int n, input int budget, input string tag);
    int b = 0;
    while (val_t.size() < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    chk(tag, 32'(val_t.size() >= n), 32'd1);
  endtask

  task automatic wait_rise(input int n, input int budget, input string tag);
    int b = 0;
    while (!(frame_rises == n && !adc_cs_n) && b < budget) begin
      @(negedge clk);
      b++;
    end
    chk(tag, 32'(frame_rises == n && !adc_cs_n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int b = 0;
    while (busy !== 1'b0 && b < budget) begin
      @(negedge clk);
      b++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int nv, rst_cyc, rdiv, k0;
`ifdef MIC_DC_BLOCK_EN
    int acc, e;
`endif
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
    chk("rst_sclk", 32'(adc_sclk), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

`ifdef MIC_DC_BLOCK_EN
    // Constant 0xC00 input: output starts at raw value and decays to midscale.
    fixed_mode = 1'b1;
    fixed_word = 12'hC00;
    div = 8'd2;
    en = 1'b1;
    wait_valid(64, 64 * 100 + 500, "dc_timeout");
    acc = 2048;
    for (int k = 0; k < 64 && k < val_s.size(); k++) begin
      e = 192 - acc / 16 + 128;
      if (e < 0) e = 0;
      if (e > 255) e = 255;
      chk($sformatf("dc_sample%0d", k), 32'(val_s[k]), 32'(e));
      acc = acc + 192 - acc / 16;
    end
    if (val_s.size() >= 64) begin
      chk("dc_first", 32'(val_s[0]), 32'h0C0);
      chk("dc_final", 32'(val_s[63] >= 8'd127 && val_s[63] <= 8'd129), 32'd1);
    end
    en = 1'b0;
`else
    // Fixed word 0xA5C at div=3.
    en = 1'b1;
    wait_valid(1, 400, "t1_timeout");
    fixed_mode = 1'b0;
    if (val_t.size() >= 1) begin
      chk("t1_sample", 32'(val_s[0]), 32'h0A5);
      chk("t1_sclk_period", 32'(rise_t[1] - rise_t[0]), 32'd8);
      chk("t1_rises", 32'(rise_t.size()), 32'd12);
      chk("t1_cs_low_clk", 32'(cs_len[0]), 32'(25 * 4));
    end

    // Continuous random frames: spacing and deserialised MSBs.
    wait_valid(4, 4 * 130, "t2_timeout");
    for (int k = 0; k < 3 && k + 1 < val_t.size(); k++) begin
      chk($sformatf("t2_spacing%0d", k), 32'(val_t[k+1] - val_t[k]), 32'd121);
      chk($sformatf("t2_sample%0d", k), 32'(val_s[k+1]), 32'(val_w[k+1] >> 4));
    end

    // en dropped at 5th sclk rising edge.
    wait_rise(5, 200, "t3_rise_timeout");
    en = 1'b0;
    nv = val_t.size();
    wait_valid(nv + 1, 200, "t3_timeout");
    if (val_t.size() > nv) chk("t3_sample", 32'(val_s[nv]), 32'(val_w[nv] >> 4));
    repeat (300) @(negedge clk);
    chk("t3_one_valid", 32'(val_t.size()), 32'(nv + 1));
    chk("t3_cs_n", 32'(adc_cs_n), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);

    // Reset mid-SHIFT aborts the frame without a sample.
    en = 1'b1;
    wait_rise(3, 200, "t4_rise_timeout");
    rst = 1'b1;
    @(negedge clk);
    rst_cyc = cyc;
    chk("t4_cs_n", 32'(adc_cs_n), 32'd1);
    chk("t4_sclk", 32'(adc_sclk), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_valid", 32'(sample_valid), 32'd0);
    chk("t4_sample_cleared", 32'(sample), 32'd0);
    rst = 1'b0;
    fixed_mode = 1'b1;
    fixed_word = 12'h3C7;
    nv = val_t.size();
    wait_valid(nv + 1, 300, "t4_timeout");
    if (val_t.size() > nv) begin
      chk("t4_new_sample", 32'(val_s[nv]), 32'h03C);
      chk("t4_full_frame", 32'(val_t[nv] - rst_cyc > 100), 32'd1);
    end
    en = 1'b0;

    // div=0 clamps to a 3-clk tick; all-ones word.
    wait_idle(300, "t5_idle_timeout");
    div = 8'd0;
    fixed_word = 12'hFFF;
    en = 1'b1;
    nv = val_t.size();
    wait_valid(nv + 1, 300, "t5_timeout");
    en = 1'b0;
    if (val_t.size() > nv) begin
      chk("t5_sample", 32'(val_s[nv]), 32'h0FF);
      chk("t5_sclk_period", 32'(rise_t[rise_t.size()-1] - rise_t[rise_t.size()-2]), 32'd6);
    end

    // Random divider, random words, three frames.
    wait_idle(300, "t6_idle_timeout");
    rdiv = $urandom_range(2, 6);
    div = 8'(rdiv);
    fixed_mode = 1'b0;
    k0 = val_t.size();
    en = 1'b1;
    wait_valid(k0 + 3, 3 * 240 + 100, "t6_timeout");
    en = 1'b0;
    for (int k = k0; k < k0 + 3 && k < val_t.size(); k++) begin
      chk($sformatf("t6_sample%0d", k - k0), 32'(val_s[k]), 32'(val_w[k] >> 4));
      if (k > k0)
        chk($sformatf("t6_spacing%0d", k - k0), 32'(val_t[k] - val_t[k-1]), 32'((rdiv + 1) * 30 + 1));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
